load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter MISALIGN_TRAP, default 1, meaning: 1 = misaligned accesses are suppressed and flagged; 0 = address low bits are ignored and forced to natural alignment.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  1  MEM-stage instruction carries a memory op this cycle.
REQ-005 mem_read  input  1  load request.
REQ-006 mem_write  input  1  store request (mem_read and mem_write never both 1).
REQ-007 funct3  input  3  RV32 width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 address  input  32  byte address from ALU.
REQ-009 store_data  input  32  rs2 value.
REQ-010 stall  output  1  hold MEM stage and all upstream stages.
REQ-011 load_data  output  32  registered, extended load result.
REQ-012 load_valid  output  1  load_data valid this cycle.
REQ-013 misaligned  output  1  one-cycle pulse, misaligned access suppressed.
REQ-014 dm_address  output  32  word-aligned address to data memory ([1:0]=00).
REQ-015 dm_write_data  output  32  word to data memory.
REQ-016 dm_mem_write  output  1  data memory write enable, written on next rising edge.
REQ-017 dm_mem_read  output  1  data memory read enable.
REQ-018 dm_read_data  input  32  combinational read word from data memory.

Function
REQ-019 FSM states IDLE and MERGE only; reset state IDLE.
REQ-020 Load (IDLE, req_valid, mem_read, aligned): dm_mem_read=1 same cycle; byte/half selected by address[1:0]; B/H sign-extended, BU/HU zero-extended, W passed through; result registered, load_valid=1 exactly one cycle later; no stall.
REQ-021 SW (IDLE, aligned): dm_mem_write=1, dm_write_data=store_data, same cycle; no stall.
REQ-022 SB/SH, IDLE cycle: dm_mem_read=1, read word captured into merge register with store_data[7:0] / [15:0] inserted at lane address[1:0]; stall=1; next state MERGE.
REQ-023 MERGE cycle: dm_mem_write=1, dm_write_data=merge register, dm_address=captured word address, stall=0, next state IDLE; inputs ignored in MERGE.
REQ-024 Sub-word store total latency 2 cycles; upstream holds all request inputs stable while stall=1.
REQ-025 Alignment: W requires address[1:0]=00, H/HU require address[0]=0; B always aligned.
REQ-026 MISALIGN_TRAP=1 and misaligned: no dm_mem_read/dm_mem_write, misaligned=1 for one cycle, load_valid stays 0, FSM stays IDLE.
REQ-027 MISALIGN_TRAP=0: misaligned access treated as aligned to next lower natural boundary; misaligned never asserted.
REQ-028 req_valid=0 or neither read nor write: dm_mem_read=dm_mem_write=0, load_valid=0 next cycle, load_data holds.
REQ-029 Reserved funct3 (011, 110, 111): treated as no-op, no memory strobes.
REQ-030 dm_mem_read and dm_mem_write never both 1 in a cycle.

Reset
REQ-031 rst_n low asynchronously forces state IDLE, load_data=0, load_valid=0, misaligned=0, merge register=0, captured address=0.
REQ-032 Reset asserted in MERGE aborts the store: no write issued; dm_mem_write deasserts immediately.
REQ-033 Combinational outputs while rst_n low: stall=0, dm_mem_read=0, dm_mem_write=0.

Structure
REQ-034 funct3 width codes and FSM state encodings in shared package rv32_mem_pkg.
REQ-035 Lane extract/extend logic in sub-module load_extend (combinational, data word + offset + funct3 -> 32-bit result), reused in merge path for lane selection.

Verification
REQ-036 Mem[0x100]=0x8899AABB; LB 0x101 -> load_data=0xFFFFFFAA next cycle; LBU 0x101 -> 0x000000AA; LH 0x102 -> 0xFFFF8899; LW 0x100 -> 0x8899AABB.
REQ-037 Mem[0x100]=0x11223344; SB 0x102, store_data=0xDEADBEEF -> stall=1 one cycle, then write 0x11EF3344; SH 0x100 data 0x0000CAFE -> 0x11EFCAFE.
REQ-038 SW 0x104 data 0x12345678 -> dm_mem_write=1 same cycle, stall=0, read-back 0x12345678.
REQ-039 LW 0x102, MISALIGN_TRAP=1 -> misaligned pulse, no strobes, load_valid=0; SH 0x103 -> misaligned, memory unchanged.
REQ-040 SB issued, rst_n low during MERGE -> no write, memory unchanged, state IDLE, outputs zeroed.
REQ-041 Back-to-back SB 0x200, LW 0x200 -> LW starts after stall drops and returns merged word.

Source files
------------

// File: rtl/rv32_mem_pkg.sv
// rv32_mem_pkg
//   Shared definitions for the RV32 load/store path:
//   - funct3 width codes (B, H, W, BU, HU)
//   - load/store FSM state encodings (IDLE, MERGE)
//   - helpers that classify a funct3 code and compute natural alignment
package rv32_mem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam int         STATE_W  = 1;
   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_MERGE = 1'b1;

   // Width codes a load may carry; everything else is a no-op.
   function automatic logic load_f3_ok(input logic [2:0] f3);
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
             (f3 == F3_BU) || (f3 == F3_HU);
   endfunction

   // Stores only come in B, H and W flavours.
   function automatic logic store_f3_ok(input logic [2:0] f3);
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
   endfunction

   // True when the byte offset sits on the natural boundary of the width.
   function automatic logic f3_aligned(input logic [2:0] f3, input logic [1:0] off);
      logic ok;
      case (f3)
         F3_W:       ok = (off == 2'b00);
         F3_H, F3_HU: ok = (off[0] == 1'b0);
         default:    ok = 1'b1;
      endcase
      return ok;
   endfunction

   // Round the byte offset down to the natural boundary of the width.
   function automatic logic [1:0] align_offset(input logic [2:0] f3, input logic [1:0] off);
      logic [1:0] r;
      case (f3)
         F3_W:       r = 2'b00;
         F3_H, F3_HU: r = {off[1], 1'b0};
         default:    r = off;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/load_extend.sv
// load_extend
//   Combinational lane extraction: picks the byte or halfword addressed by
//   offset out of a 32-bit word and sign- or zero-extends it per funct3.
//   Ports:
//     word   [31:0] in   source word
//     offset [1:0]  in   byte offset of the lane (already naturally aligned)
//     funct3 [2:0]  in   width code; unknown codes pass the word through
//     result [31:0] out  extended lane
module load_extend
   import rv32_mem_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  offset,
   input  logic [2:0]  funct3,
   output logic [31:0] result
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      case (offset)
         2'd0:    byte_sel = word[7:0];
         2'd1:    byte_sel = word[15:8];
         2'd2:    byte_sel = word[23:16];
         default: byte_sel = word[31:24];
      endcase
      half_sel = offset[1] ? word[31:16] : word[15:0];

      case (funct3)
         F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
         F3_BU:   result = {24'd0, byte_sel};
         F3_H:    result = {{16{half_sel[15]}}, half_sel};
         F3_HU:   result = {16'd0, half_sel};
         default: result = word;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit
//   MEM-stage load/store unit for an RV32 pipeline talking to a word-wide
//   data memory with combinational read and clocked write.
//   - Loads: one memory read, lane extracted/extended, registered result.
//   - SW:    single-cycle write.
//   - SB/SH: read-modify-write; IDLE cycle reads and builds the merged word,
//            MERGE cycle writes it back.
//   Stall handshake: while stall=1 the upstream holds req_valid and every
//   request input unchanged; the request is considered consumed on the
//   first rising edge where stall=0.
//   Ports:
//     clk, rst_n                 clock, async active-low reset
//     req_valid, mem_read,
//     mem_write, funct3,
//     address, store_data        request from the MEM stage
//     stall                      hold MEM and upstream stages
//     load_data, load_valid      registered load result, one cycle after request
//     misaligned                 registered one-cycle pulse for a trapped access
//     dm_address, dm_write_data,
//     dm_mem_write, dm_mem_read,
//     dm_read_data               data memory interface
//     state_dbg                  current FSM state (ST_IDLE / ST_MERGE)
module load_store_unit
   import rv32_mem_pkg::*;
#(
   parameter bit MISALIGN_TRAP = 1'b1
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req_valid,
   input  logic               mem_read,
   input  logic               mem_write,
   input  logic [2:0]         funct3,
   input  logic [31:0]        address,
   input  logic [31:0]        store_data,
   output logic               stall,
   output logic [31:0]        load_data,
   output logic               load_valid,
   output logic               misaligned,
   output logic [31:0]        dm_address,
   output logic [31:0]        dm_write_data,
   output logic               dm_mem_write,
   output logic               dm_mem_read,
   input  logic [31:0]        dm_read_data,
   output logic [STATE_W-1:0] state_dbg
);

   logic [STATE_W-1:0] state;
   logic [31:0]        merge_q;
   logic [31:0]        cap_addr;

   logic        idle, in_merge;
   logic        is_load, is_store, width_ok, trap, go;
   logic        go_load, go_sw, go_sub;
   logic [1:0]  eff_off;
   logic [2:0]  lane_f3;
   logic [31:0] ext_result, old_lane, new_lane, merged;

   always_comb begin
      idle     = (state == ST_IDLE);
      in_merge = (state == ST_MERGE);
      // mem_read wins if both ever arrive together, so the two strobes stay exclusive.
      is_load  = req_valid & mem_read;
      is_store = req_valid & mem_write & ~mem_read;
      width_ok = is_load ? load_f3_ok(funct3) : (is_store & store_f3_ok(funct3));
      trap     = MISALIGN_TRAP & width_ok & ~f3_aligned(funct3, address[1:0]);
      go       = idle & width_ok & ~trap;
      go_load  = go & is_load;
      go_sw    = go & is_store & (funct3 == F3_W);
      go_sub   = go & is_store & (funct3 != F3_W);
      // With trapping on, only aligned accesses reach here, so rounding is a no-op;
      // with trapping off it implements the round-down behaviour.
      eff_off  = align_offset(funct3, address[1:0]);
      // Store codes B/H map onto BU/HU so the old lane comes out zero-extended.
      lane_f3  = {1'b1, funct3[1:0]};
      new_lane = funct3[0] ? {16'd0, store_data[15:0]} : {24'd0, store_data[7:0]};
      // XOR out the old lane and XOR in the new one at the same position.
      merged   = dm_read_data ^ ((old_lane ^ new_lane) << {eff_off, 3'b000});
   end

   load_extend u_load_ext (
      .word   (dm_read_data),
      .offset (eff_off),
      .funct3 (funct3),
      .result (ext_result)
   );

   load_extend u_lane_ext (
      .word   (dm_read_data),
      .offset (eff_off),
      .funct3 (lane_f3),
      .result (old_lane)
   );

   // Strobes are gated with rst_n so a reset landing mid-store kills the write at once.
   always_comb begin
      stall         = rst_n & go_sub;
      dm_mem_read   = rst_n & (go_load | go_sub);
      dm_mem_write  = rst_n & (in_merge | go_sw);
      dm_write_data = in_merge ? merge_q : store_data;
      dm_address    = in_merge ? cap_addr : {address[31:2], 2'b00};
      state_dbg     = state;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         load_data  <= 32'd0;
         load_valid <= 1'b0;
         misaligned <= 1'b0;
         merge_q    <= 32'd0;
         cap_addr   <= 32'd0;
      end else begin
         load_valid <= go_load;
         misaligned <= idle & trap;
         if (go_load) begin
            load_data <= ext_result;
         end
         if (go_sub) begin
            merge_q  <= merged;
            cap_addr <= {address[31:2], 2'b00};
            state    <= ST_MERGE;
         end else begin
            state    <= ST_IDLE;
         end
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
`timescale 1ns/1ps
module tb_load_store_unit;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic        req_valid = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
   logic [2:0]  funct3 = 3'd0;
   logic [31:0] address = 32'd0, store_data = 32'd0;
   logic        stall, load_valid, misaligned, dm_mem_write, dm_mem_read;
   logic [31:0] load_data, dm_address, dm_write_data, dm_read_data;
   logic [0:0]  state_dbg;

   load_store_unit #(.MISALIGN_TRAP(1'b1)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid     (req_valid),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .funct3        (funct3),
      .address       (address),
      .store_data    (store_data),
      .stall         (stall),
      .load_data     (load_data),
      .load_valid    (load_valid),
      .misaligned    (misaligned),
      .dm_address    (dm_address),
      .dm_write_data (dm_write_data),
      .dm_mem_write  (dm_mem_write),
      .dm_mem_read   (dm_mem_read),
      .dm_read_data  (dm_read_data),
      .state_dbg     (state_dbg)
   );

   // ---------------- data memory (environment) ----------------
   logic [31:0] mem [0:1023];
   logic        mem_clear = 1'b1;
   assign dm_read_data = mem[dm_address[11:2]];
   always @(posedge clk) begin
      if (mem_clear) begin
         for (int i = 0; i < 1024; i++) mem[i] <= 32'd0;
      end else if (dm_mem_write) begin
         mem[dm_address[11:2]] <= dm_write_data;
      end
   end

   // ---------------- reference model state / scoreboard ----------------
   logic [31:0] ref_mem [0:1023];
   logic [31:0] exp_q[$];
   logic [31:0] last_load = 32'd0;
   bit          mis_exp = 1'b0;
   int          total = 0;
   int          bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (rst_n) begin
         chk("strobe_excl", 32'(dm_mem_read & dm_mem_write), 32'd0);
         if (load_valid) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_load: got %h expected no load at %0t", load_data, $time);
            end else begin
               logic [31:0] e;
               e = exp_q.pop_front();
               chk("load_data", load_data, e);
               last_load = e;
            end
         end else begin
            chk("load_hold", load_data, last_load);
         end
         chk("misaligned", 32'(misaligned), 32'(mis_exp));
         mis_exp = 1'b0;
      end
   end

   // ---------------- driver with behavioural model ----------------
   task automatic do_op(input bit valid, input bit rd, input bit wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] data);
      bit          is_load, is_store, w_ok, mis, go, sub;
      int          size, off, idx;
      logic [31:0] w, mask, v, exp_ld, exp_word;
      is_load  = valid && rd;
      is_store = valid && wr && !rd;
      case (f3)
         3'b000, 3'b100: size = 1;
         3'b001, 3'b101: size = 2;
         3'b010:         size = 4;
         default:        size = 0;
      endcase
      w_ok = is_load ? (size != 0) : (is_store && f3 <= 3'b010);
      mis  = w_ok && (addr % size != 0);
      go   = w_ok && !mis;
      sub  = go && is_store && size != 4;
      idx  = int'(addr[11:2]);
      off  = int'(addr % 4);
      w    = ref_mem[idx];
      mask = (size == 1) ? 32'hFF : 32'hFFFF;
      exp_ld = w;
      exp_word = data;
      if (size == 1 || size == 2) begin
         v = (w >> (8 * off)) & mask;
         if (f3[2] == 1'b0 && v[8 * size - 1]) v = v | ~mask;
         exp_ld = v;
         exp_word = (w & ~(mask << (8 * off))) | ((data & mask) << (8 * off));
      end

      req_valid = valid; mem_read = rd; mem_write = wr;
      funct3 = f3; address = addr; store_data = data;
      @(negedge clk);
      chk("stall_issue", 32'(stall), 32'(sub));
      chk("rd_strobe", 32'(dm_mem_read), 32'(go && (is_load || sub)));
      chk("wr_strobe", 32'(dm_mem_write), 32'(go && is_store && !sub));
      if (go) chk("dm_addr", dm_address, addr & ~32'd3);
      if (go && is_store && !sub) chk("sw_wdata", dm_write_data, data);
      @(posedge clk); #1;
      if (go && is_load) exp_q.push_back(exp_ld);
      if (mis) mis_exp = 1'b1;
      if (sub) begin
         @(negedge clk);
         chk("stall_merge", 32'(stall), 32'd0);
         chk("merge_wr", 32'(dm_mem_write), 32'd1);
         chk("merge_rd", 32'(dm_mem_read), 32'd0);
         chk("merge_addr", dm_address, addr & ~32'd3);
         chk("merge_wdata", dm_write_data, exp_word);
         @(posedge clk); #1;
      end
      if (go && is_store) ref_mem[idx] = exp_word;
      req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      for (int i = 0; i < 1024; i++) ref_mem[i] = 32'd0;
      #1 rst_n = 1'b0;
      // Request present during reset must not strobe memory.
      req_valid = 1'b1; mem_read = 1'b1; funct3 = 3'b010; address = 32'h100;
      #2;
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_rd", 32'(dm_mem_read), 32'd0);
      chk("rst_wr", 32'(dm_mem_write), 32'd0);
      chk("rst_load_data", load_data, 32'd0);
      chk("rst_load_valid", 32'(load_valid), 32'd0);
      chk("rst_misaligned", 32'(misaligned), 32'd0);
      chk("rst_state", 32'(state_dbg), 32'd0);
      req_valid = 1'b0; mem_read = 1'b0;
      repeat (3) @(posedge clk);
      #1 mem_clear = 1'b0; rst_n = 1'b1;
      idle_cycles(1);

      // Loads of each width from a known word.
      do_op(1, 0, 1, 3'b010, 32'h100, 32'h8899AABB);
      do_op(1, 1, 0, 3'b000, 32'h101, 32'h0);
      do_op(1, 1, 0, 3'b100, 32'h101, 32'h0);
      do_op(1, 1, 0, 3'b001, 32'h102, 32'h0);
      do_op(1, 1, 0, 3'b010, 32'h100, 32'h0);
      do_op(1, 1, 0, 3'b101, 32'h102, 32'h0);
      idle_cycles(2);

      // Sub-word stores via read-modify-write.
      do_op(1, 0, 1, 3'b010, 32'h100, 32'h11223344);
      do_op(1, 0, 1, 3'b000, 32'h102, 32'hDEADBEEF);
      do_op(1, 0, 1, 3'b001, 32'h100, 32'h0000CAFE);
      do_op(1, 1, 0, 3'b010, 32'h100, 32'h0);

      // Word store then read-back.
      do_op(1, 0, 1, 3'b010, 32'h104, 32'h12345678);
      do_op(1, 1, 0, 3'b010, 32'h104, 32'h0);

      // Misaligned accesses are trapped and leave memory alone.
      do_op(1, 1, 0, 3'b010, 32'h102, 32'h0);
      do_op(1, 0, 1, 3'b001, 32'h103, 32'hFFFF);
      do_op(1, 1, 0, 3'b010, 32'h100, 32'h0);

      // Reserved width codes and idle requests.
      do_op(1, 1, 0, 3'b011, 32'h100, 32'h0);
      do_op(1, 0, 1, 3'b111, 32'h100, 32'h5A5A5A5A);
      do_op(0, 1, 0, 3'b010, 32'h100, 32'h0);

      // Back-to-back SB then LW to the same word.
      do_op(1, 0, 1, 3'b000, 32'h200, 32'hA5);
      do_op(1, 1, 0, 3'b010, 32'h200, 32'h0);
      idle_cycles(2);

      // Reset asserted in the MERGE cycle aborts the store.
      do_op(1, 0, 1, 3'b010, 32'h180, 32'h11223344);
      idle_cycles(2);
      req_valid = 1'b1; mem_write = 1'b1; funct3 = 3'b000;
      address = 32'h181; store_data = 32'h55;
      @(negedge clk);
      chk("abort_stall", 32'(stall), 32'd1);
      @(posedge clk); #1;
      chk("abort_in_merge", 32'(state_dbg), 32'd1);
      chk("abort_wr_before", 32'(dm_mem_write), 32'd1);
      #1;
      rst_n = 1'b0; last_load = 32'd0; mis_exp = 1'b0;
      req_valid = 1'b0; mem_write = 1'b0;
      #1;
      chk("abort_wr", 32'(dm_mem_write), 32'd0);
      chk("abort_rd", 32'(dm_mem_read), 32'd0);
      chk("abort_stall_low", 32'(stall), 32'd0);
      chk("abort_state", 32'(state_dbg), 32'd0);
      chk("abort_load_data", load_data, 32'd0);
      chk("abort_load_valid", 32'(load_valid), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle_cycles(1);
      do_op(1, 1, 0, 3'b010, 32'h180, 32'h0);

      // Randomized traffic.
      for (int n = 0; n < 300; n++) begin
         int k;
         bit rd, wr, valid;
         logic [2:0] f3;
         k     = $urandom_range(0, 9);
         rd    = (k < 4);
         wr    = (k >= 4 && k < 8);
         valid = ($urandom_range(0, 7) != 0);
         if (wr) begin
            f3 = ($urandom_range(0, 9) == 0) ? 3'b011 : 3'($urandom_range(0, 2));
         end else begin
            f3 = 3'($urandom_range(0, 7));
         end
         do_op(valid, rd, wr, f3, 32'h300 + 32'($urandom_range(0, 63)), $urandom);
         if ($urandom_range(0, 3) == 0) idle_cycles(1);
      end

      idle_cycles(3);
      chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
      begin
         int diffs;
         diffs = 0;
         for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) diffs++;
         chk("mem_image_diffs", 32'(diffs), 32'd0);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
